// File: rtl/booth_divider.sv
// -----------------------------------------------------------------------------
// booth_divider
//
// Sequential signed divider for the toy ALU arithmetic unit, the companion of
// the combinational Booth multiplier. The two operands are latched on a
// start/done handshake. Radix-2 restoring division runs on their magnitudes,
// one quotient bit per clock. A sign fix-up then makes the results match
// Verilog '/' and '%' on signed operands:
//   - the quotient truncates toward zero;
//   - the remainder takes the sign of the dividend.
//
// Latency is fixed at WIDTH+1 edges from the accepting edge to the done cycle,
// for every operand pair.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request pulse, sampled only while idle
//   A            signed dividend (WIDTH bits)
//   B            signed divisor  (WIDTH bits)
//   busy         high from the cycle after start is accepted until done
//   done         single-cycle pulse; results valid from this cycle
//   quo          signed quotient, held until the next operation completes
//   rem          signed remainder, held until the next operation completes
//   div_by_zero  B was zero for this operation (held with the results)
//   ovf          A was the most-negative value and B was -1 (held)
// -----------------------------------------------------------------------------
module booth_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem,
   output logic             div_by_zero,
   output logic             ovf
);

   localparam int               CW        = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t state;

   // Operands as presented. These are kept for the divide-by-zero and
   // overflow overrides at FIX.
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             sign_q;
   logic             sign_r;

   // Magnitudes are WIDTH+1 bits wide, so 2^(WIDTH-1) is represented exactly.
   // a_mag doubles as the dividend/quotient shift register: dividend bits
   // leave at the top while quotient bits enter at the bottom.
   logic [WIDTH:0]   a_mag;
   logic [WIDTH:0]   b_mag;
   logic [WIDTH:0]   part_rem;
   logic [CW-1:0]    count;

   // Combinational datapath
   logic [WIDTH:0]   a_abs;
   logic [WIDTH:0]   b_abs;
   logic [WIDTH:0]   shifted_rem;
   logic [WIDTH+1:0] trial;
   logic             q_bit;
   logic [WIDTH:0]   next_rem;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   always_comb begin
      // NOTE: every variable gets a value before any condition touches it,
      // so no path leaves one unassigned and no latch can be inferred.
      a_abs = {1'b0, A};
      b_abs = {1'b0, B};
      if (A[WIDTH-1]) a_abs = {1'b0, ~A} + 1'b1;
      if (B[WIDTH-1]) b_abs = {1'b0, ~B} + 1'b1;

      // One restoring step. The partial remainder stays below |B| <= 2^(WIDTH-1),
      // so dropping its top bit during the shift loses nothing.
      shifted_rem = {part_rem[WIDTH-1:0], a_mag[WIDTH-1]};
      trial       = {1'b0, shifted_rem} - {1'b0, b_mag};
      q_bit       = ~trial[WIDTH+1];
      next_rem    = q_bit ? trial[WIDTH:0] : shifted_rem;

      // Sign fix-up. Two's-complement negation of zero is zero, so a zero
      // magnitude stays positive zero whatever the sign flag is.
      q_fix = a_mag[WIDTH-1:0];
      r_fix = part_rem[WIDTH-1:0];
      if (sign_q) q_fix = ~a_mag[WIDTH-1:0] + 1'b1;
      if (sign_r) r_fix = ~part_rem[WIDTH-1:0] + 1'b1;
   end

   // The top bits of the magnitude and remainder registers are always zero
   // once the shift is underway. They are gathered here so that they are
   // visibly accounted for.
   logic unused_bits;
   assign unused_bits = ^{a_mag[WIDTH], part_rem[WIDTH]};

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state only ever uses non-blocking assignments. Every
      // right-hand side therefore sees the pre-edge values, whatever order the
      // statements appear in.
      if (rst) begin
         // NOTE: the datapath registers are reset along with the control
         // state. An abandoned operation leaves no residue that could be
         // observed later.
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quo         <= '0;
         rem         <= '0;
         div_by_zero <= 1'b0;
         ovf         <= 1'b0;
         a_reg       <= '0;
         b_reg       <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         a_mag       <= '0;
         b_mag       <= '0;
         part_rem    <= '0;
         count       <= '0;
      end else begin
         done <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  a_reg    <= A;
                  b_reg    <= B;
                  sign_q   <= A[WIDTH-1] ^ B[WIDTH-1];
                  sign_r   <= A[WIDTH-1];
                  a_mag    <= a_abs;
                  b_mag    <= b_abs;
                  part_rem <= '0;
                  count    <= '0;
                  busy     <= 1'b1;
                  state    <= CALC;
               end
            end

            CALC: begin
               part_rem <= next_rem;
               a_mag    <= {1'b0, a_mag[WIDTH-2:0], q_bit};
               count    <= count + 1'b1;
               if (count == LAST_ITER) state <= FIX;
            end

            FIX: begin
               // A zero divisor still runs the full loop, so latency is the
               // same for every operand pair. Only the outcome is replaced.
               if (b_reg == '0) begin
                  quo         <= '1;
                  rem         <= a_reg;
                  div_by_zero <= 1'b1;
                  ovf         <= 1'b0;
               end else if (a_reg == MOST_NEG && b_reg == '1) begin
                  quo         <= MOST_NEG;
                  rem         <= '0;
                  div_by_zero <= 1'b0;
                  ovf         <= 1'b1;
               end else begin
                  quo         <= q_fix;
                  rem         <= r_fix;
                  div_by_zero <= 1'b0;
                  ovf         <= 1'b0;
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_divider.sv
// -----------------------------------------------------------------------------
// tb_booth_divider
//
// Directed and randomized checks of booth_divider at WIDTH = 16. Expected
// values are either hand-computed constants or come from a '/' and '%'
// reference with explicit zero-divisor and overflow cases.
// -----------------------------------------------------------------------------
module tb_booth_divider;

   localparam int WIDTH   = 16;
   localparam int LATENCY = WIDTH + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [WIDTH-1:0]  A;
   logic [WIDTH-1:0]  B;
   logic              busy;
   logic              done;
   logic [WIDTH-1:0]  quo;
   logic [WIDTH-1:0]  rem;
   logic              div_by_zero;
   logic              ovf;

   int n_checks = 0;
   int n_errors = 0;

   // Results of the most recent completed operation. Outputs must hold these
   // values while the next operation is in flight.
   logic [WIDTH-1:0]  prev_q;
   logic [WIDTH-1:0]  prev_r;
   logic              prev_dz;
   logic              prev_ov;

   always #5 clk = ~clk;

   booth_divider #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .quo         (quo),
      .rem         (rem),
      .div_by_zero (div_by_zero),
      .ovf         (ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                   output logic dz, output logic ov);
      int ia;
      int ib;
      ia = int'($signed(a));
      ib = int'($signed(b));
      dz = 1'b0;
      ov = 1'b0;
      if (ib == 0) begin
         q  = '1;
         r  = a;
         dz = 1'b1;
      end else if (ia == -32768 && ib == -1) begin
         q  = 16'h8000;
         r  = '0;
         ov = 1'b1;
      end else begin
         q = 16'(ia / ib);
         r = 16'(ia % ib);
      end
   endfunction

   // Issue one operation, follow it to done and check the timing and results.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                         input logic edz, input logic eov);
      int lat;
      bit seen;
      @(negedge clk);
      A     = a;
      B     = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "/busy_at_accept"}, 32'(busy), 32'd1);
      check({tag, "/done_at_accept"}, 32'(done), 32'd0);
      // Operands are don't-care after the accepting edge.
      A = 16'($urandom);
      B = 16'($urandom);
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) begin
            seen = 1'b1;
         end else if (lat == 8) begin
            check({tag, "/hold_quo"}, 32'(quo), 32'(prev_q));
            check({tag, "/hold_rem"}, 32'(rem), 32'(prev_r));
            check({tag, "/hold_dz"},  32'(div_by_zero), 32'(prev_dz));
            check({tag, "/hold_ovf"}, 32'(ovf), 32'(prev_ov));
         end else if (lat == WIDTH) begin
            check({tag, "/busy_last"}, 32'(busy), 32'd1);
         end
      end
      check({tag, "/latency"},   32'(lat), 32'(LATENCY));
      check({tag, "/busy_done"}, 32'(busy), 32'd0);
      check({tag, "/quo"}, 32'(quo), 32'(eq));
      check({tag, "/rem"}, 32'(rem), 32'(er));
      check({tag, "/dz"},  32'(div_by_zero), 32'(edz));
      check({tag, "/ovf"}, 32'(ovf), 32'(eov));
      prev_q  = eq;
      prev_r  = er;
      prev_dz = edz;
      prev_ov = eov;
   endtask

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] eq;
      logic [WIDTH-1:0] er;
      logic edz;
      logic eov;
      bit   seen;
      int   done_cnt;
      int   last_done;

      rst     = 1'b1;
      start   = 1'b0;
      A       = '0;
      B       = '0;
      prev_q  = '0;
      prev_r  = '0;
      prev_dz = 1'b0;
      prev_ov = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset/busy", 32'(busy), 32'd0);
      check("reset/done", 32'(done), 32'd0);
      check("reset/quo",  32'(quo),  32'd0);
      check("reset/rem",  32'(rem),  32'd0);
      check("reset/dz",   32'(div_by_zero), 32'd0);
      check("reset/ovf",  32'(ovf),  32'd0);
      rst = 1'b0;

      // Sign combinations
      run_op("pos_pos", 16'd100,   16'd7,      16'd14,   16'd2,    1'b0, 1'b0);
      run_op("neg_pos", -16'sd100, 16'd7,      16'hFFF2, 16'hFFFE, 1'b0, 1'b0);
      run_op("pos_neg", 16'd100,   -16'sd7,    16'hFFF2, 16'd2,    1'b0, 1'b0);
      run_op("neg_neg", -16'sd100, -16'sd7,    16'd14,   16'hFFFE, 1'b0, 1'b0);

      // Asynchronous reset eight edges into an operation
      @(negedge clk);
      A     = 16'd1000;
      B     = 16'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst/busy", 32'(busy), 32'd0);
      check("midrst/done", 32'(done), 32'd0);
      check("midrst/quo",  32'(quo),  32'd0);
      check("midrst/rem",  32'(rem),  32'd0);
      check("midrst/dz",   32'(div_by_zero), 32'd0);
      check("midrst/ovf",  32'(ovf),  32'd0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      check("midrst/no_done", 32'(seen), 32'd0);
      prev_q  = '0;
      prev_r  = '0;
      prev_dz = 1'b0;
      prev_ov = 1'b0;
      run_op("after_rst", 16'd50, 16'd6, 16'd8, 16'd2, 1'b0, 1'b0);

      // Boundaries
      run_op("ovf",       16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1);
      run_op("min_by_1",  16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0);
      run_op("max_by_min",16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0, 1'b0);
      run_op("zero_a",    16'h0000, -16'sd5,  16'h0000, 16'h0000, 1'b0, 1'b0);
      run_op("small_neg", -16'sd7,  16'd100,  16'h0000, 16'hFFF9, 1'b0, 1'b0);

      // Divide by zero, then a normal operation clears the flag
      run_op("div0",      16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1'b0);
      run_op("after_div0",16'd9, 16'd3, 16'd3,    16'd0, 1'b0, 1'b0);

      // start held high, operands changing every cycle except at idle edges
      @(negedge clk);
      A         = 16'd100;
      B         = 16'd7;
      start     = 1'b1;
      done_cnt  = 0;
      last_done = 0;
      for (int cyc = 1; cyc <= 60 && done_cnt < 2; cyc++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) begin
               check("hs1/quo", 32'(quo), 32'h0000_000E);
               check("hs1/rem", 32'(rem), 32'h0000_0002);
               last_done = cyc;
               A = -16'sd1000;
               B = 16'd33;
            end else begin
               check("hs2/quo", 32'(quo), 32'h0000_FFE2);
               check("hs2/rem", 32'(rem), 32'h0000_FFF6);
               check("hs/gap",  32'(cyc - last_done), 32'd18);
               start = 1'b0;
            end
         end else begin
            A = 16'($urandom);
            B = 16'($urandom);
         end
      end
      start = 1'b0;
      check("hs/pulses", 32'(done_cnt), 32'd2);
      repeat (20) @(posedge clk);
      prev_q  = 16'hFFE2;
      prev_r  = 16'hFFF6;
      prev_dz = 1'b0;
      prev_ov = 1'b0;

      // Randomized pairs with forced corners
      for (int i = 0; i < 2000; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         case (i % 8)
            0: b = '0;
            1: a = '0;
            2: begin
               b = 16'($urandom_range(1, 8));
               if ($urandom_range(0, 1) == 1) b = -b;
            end
            default: ;
         endcase
         if (i % 100 == 50) begin
            a = 16'h8000;
            b = 16'hFFFF;
         end
         ref_div(a, b, eq, er, edz, eov);
         run_op("rand", a, b, eq, er, edz, eov);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
